// File: rtl/rgb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pattern_sequencer
// Brief    : Frame-synchronous 8-colour test-pattern selector. It auto-advances
//            through the palette and accepts manual requests. Optional macro
//            RGB_SEQ_SKIP_BLACK_EN removes black from auto-advance.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pattern_sequencer #(
  parameter int HOLD_FRAMES = 60,
  parameter int VSYNC_POL   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vsync,
  input  logic        i_auto_en,
  input  logic        i_req_valid,
  input  logic [2:0]  i_req_sel,
  output logic        o_req_ready,
  output logic        o_frame_start,
  output logic [2:0]  o_pattern_sel,
  output logic [23:0] o_color
);

  localparam logic        c_VS_ACTIVE = 1'(VSYNC_POL);
  localparam logic [11:0] c_HOLD_LAST = 12'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTO = 2'd1,
    PEND = 2'd2
  } mode_t;

  logic        r_vs_prev;
  logic        r_pending;
  logic [2:0]  r_pend_sel;
  logic [11:0] r_cnt;
  logic [2:0]  r_sel;
  logic [23:0] r_color;
  logic        r_frame_start;

  logic        w_vs_active;
  logic        w_boundary;
  logic        w_accept;
  logic [2:0]  w_auto_next;
  mode_t       w_mode;

  function automatic logic [23:0] f_palette(input logic [2:0] idx);
    case (idx)
      3'd0:    f_palette = 24'hFF0000;
      3'd1:    f_palette = 24'hFF7F00;
      3'd2:    f_palette = 24'hFFFF00;
      3'd3:    f_palette = 24'h00FF00;
      3'd4:    f_palette = 24'h0000FF;
      3'd5:    f_palette = 24'h4B0082;
      3'd6:    f_palette = 24'h9400D3;
      default: f_palette = 24'h000000;
    endcase
  endfunction

  assign w_vs_active = (i_vsync == c_VS_ACTIVE);
  assign w_boundary  = w_vs_active && !r_vs_prev;
  assign w_accept    = i_req_valid && !r_pending;

  always_comb begin
    w_auto_next = r_sel + 3'd1;
`ifdef RGB_SEQ_SKIP_BLACK_EN
    if (r_sel == 3'd6) begin
      w_auto_next = 3'd0;
    end
`endif
  end

  always_comb begin
    w_mode = IDLE;
    if (r_pending) begin
      w_mode = PEND;
    end else if (i_auto_en) begin
      w_mode = AUTO;
    end
  end

  // Reset loads r_vs_prev as "active" so a vsync already asserted at release is not a boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev     <= 1'b1;
      r_pending     <= 1'b0;
      r_pend_sel    <= 3'd0;
      r_cnt         <= 12'd0;
      r_sel         <= 3'd0;
      r_color       <= 24'hFF0000;
      r_frame_start <= 1'b0;
    end else begin
      r_vs_prev     <= w_vs_active;
      r_frame_start <= w_boundary;

      // Acceptance only when nothing is pending, so it never collides with the PEND clear.
      if (w_accept) begin
        r_pending  <= 1'b1;
        r_pend_sel <= i_req_sel;
      end

      if (w_boundary) begin
        case (w_mode)
          PEND: begin
            r_sel     <= r_pend_sel;
            r_color   <= f_palette(r_pend_sel);
            r_cnt     <= 12'd0;
            r_pending <= 1'b0;
          end
          AUTO: begin
            if (r_cnt == c_HOLD_LAST) begin
              r_sel   <= w_auto_next;
              r_color <= f_palette(w_auto_next);
              r_cnt   <= 12'd0;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          default: r_cnt <= 12'd0;
        endcase
      end else if (!i_auto_en) begin
        r_cnt <= 12'd0;
      end
    end
  end

  assign o_req_ready   = !r_pending;
  assign o_frame_start = r_frame_start;
  assign o_pattern_sel = r_sel;
  assign o_color       = r_color;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pattern_sequencer
// Brief    : Directed self-checking bench. Two instances are used, with
//            HOLD_FRAMES 2 and 1, and both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        auto_en = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_sel = 3'd0;

  logic        ready0, fs0, ready1, fs1;
  logic [2:0]  sel0, sel1;
  logic [23:0] col0, col1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rgb_pattern_sequencer #(.HOLD_FRAMES(2), .VSYNC_POL(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_auto_en(auto_en),
    .i_req_valid(req_valid), .i_req_sel(req_sel), .o_req_ready(ready0),
    .o_frame_start(fs0), .o_pattern_sel(sel0), .o_color(col0)
  );

  rgb_pattern_sequencer #(.HOLD_FRAMES(1), .VSYNC_POL(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_auto_en(auto_en),
    .i_req_valid(req_valid), .i_req_sel(req_sel), .o_req_ready(ready1),
    .o_frame_start(fs1), .o_pattern_sel(sel1), .o_color(col1)
  );

  function automatic logic [23:0] pal(input int idx);
    case (idx)
      0:       pal = 24'hFF0000;
      1:       pal = 24'hFF7F00;
      2:       pal = 24'hFFFF00;
      3:       pal = 24'h00FF00;
      4:       pal = 24'h0000FF;
      5:       pal = 24'h4B0082;
      6:       pal = 24'h9400D3;
      default: pal = 24'h000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vsync goes active; outputs after this edge show the boundary result.
  task automatic boundary();
    vsync = 1'b0;
    tick();
  endtask

  task automatic gap();
    tick();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int fs_seen;
    int exp;

    // Reset with vsync held active: no boundary after release.
    vsync = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fs0 || fs1) fs_seen++;
    end
    check("rst_no_fs", fs_seen, 0);
    check("rst_sel", sel0, 0);
    check("rst_col", col0, 24'hFF0000);
    check("rst_ready", ready0, 1);

    // Auto-advance, HOLD_FRAMES = 2.
    auto_en = 1'b1;
    vsync = 1'b1;
    repeat (3) tick();
    for (int k = 1; k <= 16; k++) begin
`ifdef RGB_SEQ_SKIP_BLACK_EN
      exp = (k / 2) % 7;
`else
      exp = (k / 2) % 8;
`endif
      boundary();
      check("auto_fs", fs0, 1);
      check("auto_sel", sel0, exp);
      check("auto_col", col0, pal(exp));
      tick();
      check("fs_width", fs0, 0);
      vsync = 1'b1;
      repeat (3) tick();
    end

    // Manual request with auto still enabled: counter goes to 1 first.
    boundary();
    check("pre_man_sel", sel0, 0);
    gap();
    req_valid = 1'b1;
    req_sel = 3'd4;
    tick();
    check("man_ready_low", ready0, 0);
    req_sel = 3'd6;
    repeat (3) tick();
    check("man_ready_held", ready0, 0);
    req_valid = 1'b0;
    tick();
    boundary();
    check("man_fs", fs0, 1);
    check("man_sel", sel0, 4);
    check("man_col", col0, 24'h0000FF);
    check("man_ready_up", ready0, 1);
    gap();
    boundary();
    check("man_cnt_clr", sel0, 4);
    gap();
    auto_en = 1'b0;

    // Collision: acceptance on the boundary cycle applies one frame later.
    vsync = 1'b0;
    req_valid = 1'b1;
    req_sel = 3'd5;
    tick();
    req_valid = 1'b0;
    check("col_fs", fs0, 1);
    check("col_sel_old", sel0, 4);
    check("col_ready", ready0, 0);
    gap();
    boundary();
    check("col_sel_new", sel0, 5);
    check("col_col_new", col0, 24'h4B0082);
    check("col_ready_up", ready0, 1);
    gap();

    // Priority with HOLD_FRAMES = 1.
    rst_n = 1'b0;
    tick();
    vsync = 1'b1;
    rst_n = 1'b1;
    tick();
    auto_en = 1'b1;
    req_valid = 1'b1;
    req_sel = 3'd2;
    tick();
    req_valid = 1'b0;
    tick();
    boundary();
    check("prio_sel1", sel1, 2);
    check("prio_col1", col1, 24'hFFFF00);
    check("prio_sel0", sel0, 2);
    gap();
    auto_en = 1'b0;
    for (int f = 0; f < 5; f++) begin
      boundary();
      check("idle_sel1", sel1, 2);
      gap();
    end
    auto_en = 1'b1;
    boundary();
    check("hold1_sel1", sel1, 3);
    check("hold1_col1", col1, 24'h00FF00);
    check("hold2_sel0", sel0, 2);
    gap();

    // Async reset mid-frame with a request pending.
    auto_en = 1'b0;
    req_valid = 1'b1;
    req_sel = 3'd6;
    tick();
    req_valid = 1'b0;
    check("ar_ready_low", ready1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_sel1", sel1, 0);
    check("ar_col1", col1, 24'hFF0000);
    check("ar_ready1", ready1, 1);
    check("ar_sel0", sel0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    boundary();
    check("ar_fs", fs1, 1);
    check("ar_no_apply", sel1, 0);
    check("ar_no_apply0", sel0, 0);
    check("ar_ready_after", ready1, 1);
    gap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_pattern_sequencer.md
# rgb_pattern_sequencer

Frame-synchronous controller for the HDMI test-pattern path: selects which of eight fixed colours the pattern generator drives. It auto-advances through the palette every HOLD_FRAMES frames and accepts manual selection requests over a valid/ready handshake. All changes are applied only at a frame boundary, so no frame ever shows two colours. It sits between the timing generator (vsync source) and the pattern generator (colour input), in the pixel-clock domain.

## Interface
- HOLD_FRAMES, 60, frames each pattern is held in auto mode; legal range 1..4095
- VSYNC_POL, 0, active level of i_vsync (0 = active-low)
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_vsync  in  1  vsync from timing generator, synchronous to i_clk
- i_auto_en  in  1  level; 1 = auto-advance enabled
- i_req_valid  in  1  manual selection request
- i_req_sel  in  3  requested pattern index, 0..7
- o_req_ready  out  1  request can be accepted
- o_frame_start  out  1  one-cycle pulse at each frame boundary
- o_pattern_sel  out  3  current pattern index
- o_color  out  24  RGB888 colour for the current index

## Operation
- Palette, index 0..7: FF0000, FF7F00, FFFF00, 00FF00, 0000FF, 4B0082, 9400D3, 000000.
- Frame boundary: i_vsync moves from the inactive to the active level. One registered previous-vsync flop is used for edge detection.
- Reset values:
  - previous-vsync flop = active level, so a vsync already active at reset release produces no boundary.
  - o_pattern_sel = 0, o_color = 24'hFF0000, o_req_ready = 1, o_frame_start = 0.
  - Frame counter = 0, pending = 0.
- Handshake:
  - A request is accepted when i_req_valid && o_req_ready. i_req_sel is latched into the pending register and pending is set.
  - o_req_ready = !pending. Only one request is outstanding at a time.
  - i_req_valid held while ready = 0 is ignored; no queueing.
- State machine, evaluated on a boundary cycle:
  - **IDLE** (pending = 0, i_auto_en = 0): frame counter held at 0; index unchanged.
  - **AUTO** (pending = 0, i_auto_en = 1):
    - If counter == HOLD_FRAMES-1: index advances by +1 mod 8 and counter clears.
    - Otherwise: counter increments.
  - **PEND** (pending = 1):
    - index <= pending sel, counter clears, pending clears.
    - Priority over auto-advance; independent of i_auto_en.
- Non-boundary cycles: counter and index are unchanged. i_auto_en 1->0 clears the counter on the next cycle.
- Simultaneous request acceptance and boundary in the same cycle: the request is latched and applied at the following boundary, not the current one. The boundary in that cycle follows IDLE/AUTO rules.
- Counter width: 12 bits, compared against HOLD_FRAMES-1. HOLD_FRAMES = 1 advances the index every frame.
- Reset mid-operation: all state returns asynchronously to reset values, and any pending request is discarded.

## Timing
- o_frame_start is high exactly one cycle: the cycle after i_vsync is first sampled active.
- o_pattern_sel and o_color update on the same clock edge that raises o_frame_start. o_color is a registered lookup of the new index, so there is no extra latency.
- o_req_ready:
  - falls the cycle after acceptance;
  - rises in the same cycle o_frame_start is high for the boundary that applies the request.
- Minimum latency from acceptance to application: 1 boundary.

## Configuration
- RGB_SEQ_SKIP_BLACK_EN
  - Defined: auto-advance skips index 7 and wraps 6 -> 0. A manual request for 7 is still accepted and applied. Auto-advance from 7 goes to 0.
  - Undefined: auto-advance cycles 0..7.

## Test plan
- **Reset:** reset with i_vsync held active, release, hold active for 10 cycles -> no o_frame_start; o_pattern_sel = 0, o_color = FF0000, o_req_ready = 1.
- **Auto-advance:** HOLD_FRAMES = 2, i_auto_en = 1, 16 frames -> index steps every 2nd frame start 0,1,..,7,0; each step coincides with o_frame_start.
  - With RGB_SEQ_SKIP_BLACK_EN defined, the sequence wraps 6 -> 0 instead.
- **Manual request:**
  - Drive req_sel = 4 mid-frame -> o_req_ready low next cycle.
  - A second request held high is ignored.
  - At the next boundary o_pattern_sel = 4, o_color = 0000FF, o_req_ready = 1, counter cleared.
- **Collision:** request (sel = 5) accepted in the same cycle as the boundary -> index is not 5 at that boundary; it becomes 5, color 4B0082, at the following boundary.
- **Priority:** HOLD_FRAMES = 1, i_auto_en = 1, pending sel = 2 at a boundary where auto would advance 0 -> 1 -> result is 2.
  - Then i_auto_en = 0 for 5 frames -> index stays 2.
- **Async reset:** assert i_rst_n low mid-frame with a request pending -> outputs return to reset values immediately (before the next clock edge); the pending request is not applied after release.
